dram_ctrl: RTL and testbench
============================

# dram_ctrl

Single-channel controller between a simple user request port and a multi-bank DRAM device. It accepts one read or write per transaction and issues ACTIVATE, READ/WRITE and PRECHARGE with the bank, row and column fields taken from the user address. It returns read data with a valid flag and issues periodic AUTO REFRESH commands. Every access is a closed-page, single-beat access.

## Interface
- NUMBER_OF_COLUMNS, 8, bits per DRAM row.
- NUMBER_OF_ROWS, 128, rows per bank.
- NUMBER_OF_BANKS, 8, banks.
- REFRESH_RATE, 1, refresh period in ms.
- CLK_FREQUENCY, 100, clock frequency in kHz.
- U_DATA_WIDTH, 2, user data width; must equal DRAM_DATA_WIDTH.
- DRAM_DATA_WIDTH, 2, DRAM word width.
- Derived localparams, never overridden:
  - COLUMN_WIDTH = clog2(NUMBER_OF_COLUMNS/DRAM_DATA_WIDTH), which is 2.
  - ROW_WIDTH = clog2(NUMBER_OF_ROWS), which is 7.
  - BANK_ID_WIDTH = clog2(NUMBER_OF_BANKS), which is 3.
  - U_ADDR_WIDTH = BANK+ROW+COL, which is 12.
  - DRAM_ADDR_WIDTH = max(ROW_WIDTH, COLUMN_WIDTH).
  - CYCLES_BETWEEN_REFRESH = CLK_FREQUENCY*REFRESH_RATE, which is 100.
  - REFRESH_COUNTER_WIDTH = clog2(CYCLES_BETWEEN_REFRESH).

Ports:
- u_clk  in  1  the single clock.
- u_rst_n  in  1  reset, asynchronous and active-low.
- u_en  in  1  request enable; a request is pending while high.
- u_addr  in  U_ADDR_WIDTH  address {bank_id, row, col}, with col in the LSBs.
- u_data_i  in  U_DATA_WIDTH  write data.
- u_cmd  in  1  1 = write, 0 = read.
- u_data_o  out  U_DATA_WIDTH  read data.
- u_data_valid  out  1  u_data_o is valid.
- u_cmd_ack  out  1  one-cycle pulse when a request is latched.
- u_busy  out  1  controller is not idle.
- dram_rd_data  in  DRAM_DATA_WIDTH  DRAM read data.
- dram_refresh_done  in  1  one-cycle pulse when the DRAM finishes a refresh.
- dram_wr_data  out  DRAM_DATA_WIDTH  DRAM write data.
- dram_addr  out  DRAM_ADDR_WIDTH  row or column address, zero-extended.
- dram_bank_id  out  BANK_ID_WIDTH  bank.
- dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n  out  1 each  command pins.
- dram_clk_en  out  1  DRAM clock enable.

## Operation
- Command encoding {cs_n, ras_n, cas_n, we_n}:
  - NOP = 0111
  - ACTIVATE = 0011
  - READ = 0101
  - WRITE = 0100
  - PRECHARGE = 0010
  - AUTO_REFRESH = 0001
  - Deselect = 1111 (reset only)
- All outputs are registered.
- FSM states: IDLE, ACTIVATE, READ, READ_WAIT, WRITE, PRECHARGE, REFRESH, REFRESH_WAIT.
- IDLE:
  - If a refresh is pending, go to REFRESH. Refresh has priority over a user request.
  - Otherwise, if u_en=1, latch u_addr, u_data_i and u_cmd, pulse u_cmd_ack, and go to ACTIVATE.
  - Otherwise drive NOP.
- ACTIVATE: drive the ACTIVATE command with dram_addr = row and dram_bank_id = bank. Next state is WRITE if u_cmd=1, else READ.
- WRITE: drive WRITE with dram_addr = col and dram_wr_data = the latched data, then go to PRECHARGE.
- READ: drive READ with dram_addr = col, then go to READ_WAIT.
- READ_WAIT:
  - Drive NOP.
  - Capture dram_rd_data into u_data_o and set u_data_valid=1.
  - Go to PRECHARGE.
- PRECHARGE: drive PRECHARGE on the latched bank, then go to IDLE.
- REFRESH: drive AUTO_REFRESH for one cycle and clear the pending flag, then go to REFRESH_WAIT.
- REFRESH_WAIT: drive NOP until dram_refresh_done=1, then go to IDLE. There is no timeout.
- Refresh counter:
  - Free-running, counting 0 to CYCLES_BETWEEN_REFRESH-1, then wrapping.
  - On wrap it sets the pending flag.
  - It counts regardless of u_en and state.
  - A wrap while the flag is already set is absorbed.
- u_busy=1 in every state except IDLE.
- u_data_valid and u_data_o hold their value until the next u_cmd_ack, where u_data_valid clears.
- Reset (asynchronous, any state):
  - State returns to IDLE; counter and pending flag clear.
  - u_data_o=0, u_data_valid=0, u_cmd_ack=0, u_busy=0.
  - dram_addr=0, dram_bank_id=0, dram_wr_data=0.
  - Command pins go to deselect (1111).
  - dram_clk_en=0, then 1 from the first clock edge after reset release.
  - Any in-flight access is dropped.

## Timing
- Write: the acceptance edge E0 has cmd_ack high for the following cycle. Then one cycle each of ACTIVATE, WRITE and PRECHARGE. u_busy is high for 3 cycles and returns to 0 at E3.
- Read: one cycle each of ACTIVATE, READ, READ_WAIT and PRECHARGE. u_busy is high for 4 cycles.
  - u_data_valid rises at E3, when READ_WAIT captures the data.
  - It stays high through and after busy falls at E4.
- The DRAM contract requires dram_rd_data to be valid by the end of the cycle that follows the READ command cycle.
- A new request is accepted no earlier than the first edge where the state is IDLE after u_busy falls.

## Configuration
- Macro DRAM_CTRL_REFRESH_EN.
- Defined: the refresh counter, pending flag, REFRESH and REFRESH_WAIT are all present, as described above.
- Undefined:
  - No refresh logic; AUTO_REFRESH is never issued.
  - dram_refresh_done is ignored.
  - IDLE accepts u_en immediately.

## Test plan
- Write addr 0x5A3 with data 2'b10, then read 0x5A3: u_cmd_ack pulses once per request, and the read returns u_data_o=2'b10 with u_data_valid=1.
- Write 2'b01 to bank 7, row 127, col 3, then read it back: the read returns 2'b01. ACTIVATE shows dram_addr=127 and dram_bank_id=7.
- Hold u_en=0 for 250 cycles: no u_cmd_ack, and AUTO_REFRESH is issued every 100 cycles. Each refresh holds u_busy until dram_refresh_done.
- Assert u_en in the cycle the refresh counter wraps: REFRESH is served first, and the request is acked only after dram_refresh_done.
- Pull u_rst_n low during READ_WAIT: all outputs return to reset values immediately. After release, a fresh write/read pair completes correctly.
- 100 random read/write requests checked against a shadow memory: zero mismatches.

Source files
------------

// File: rtl/dram_ctrl.sv
// dram_ctrl: closed-page single-beat DRAM controller (ACT -> RD/WR -> PRE); auto refresh when `DRAM_CTRL_REFRESH_EN is defined.
// Latency: u_cmd_ack one cycle after acceptance; write busy 3 cycles, read busy 4 with u_data_valid rising on READ_WAIT exit.
// Backpressure: a request waits with u_en high until u_cmd_ack; nothing is accepted while u_busy or while a refresh is due.
module dram_ctrl #(
    parameter int NUMBER_OF_COLUMNS = 8,
    parameter int NUMBER_OF_ROWS    = 128,
    parameter int NUMBER_OF_BANKS   = 8,
    parameter int REFRESH_RATE      = 1,
    parameter int CLK_FREQUENCY     = 100,
    parameter int U_DATA_WIDTH      = 2,
    parameter int DRAM_DATA_WIDTH   = 2,
    localparam int COLUMN_WIDTH           = $clog2(NUMBER_OF_COLUMNS / DRAM_DATA_WIDTH),
    localparam int ROW_WIDTH              = $clog2(NUMBER_OF_ROWS),
    localparam int BANK_ID_WIDTH          = $clog2(NUMBER_OF_BANKS),
    localparam int U_ADDR_WIDTH           = BANK_ID_WIDTH + ROW_WIDTH + COLUMN_WIDTH,
    localparam int DRAM_ADDR_WIDTH        = (ROW_WIDTH > COLUMN_WIDTH) ? ROW_WIDTH : COLUMN_WIDTH,
    localparam int CYCLES_BETWEEN_REFRESH = CLK_FREQUENCY * REFRESH_RATE,
    localparam int REFRESH_COUNTER_WIDTH  = $clog2(CYCLES_BETWEEN_REFRESH)
) (
    input  logic                       u_clk,
    input  logic                       u_rst_n,
    input  logic                       u_en,
    input  logic [U_ADDR_WIDTH-1:0]    u_addr,
    input  logic [U_DATA_WIDTH-1:0]    u_data_i,
    input  logic                       u_cmd,
    output logic [U_DATA_WIDTH-1:0]    u_data_o,
    output logic                       u_data_valid,
    output logic                       u_cmd_ack,
    output logic                       u_busy,
    input  logic [DRAM_DATA_WIDTH-1:0] dram_rd_data,
    input  logic                       dram_refresh_done,
    output logic [DRAM_DATA_WIDTH-1:0] dram_wr_data,
    output logic [DRAM_ADDR_WIDTH-1:0] dram_addr,
    output logic [BANK_ID_WIDTH-1:0]   dram_bank_id,
    output logic                       dram_cs_n,
    output logic                       dram_ras_n,
    output logic                       dram_cas_n,
    output logic                       dram_we_n,
    output logic                       dram_clk_en
);

    if (U_DATA_WIDTH != DRAM_DATA_WIDTH) begin : g_bad_width
        $error("dram_ctrl: U_DATA_WIDTH must equal DRAM_DATA_WIDTH");
    end
    if (CYCLES_BETWEEN_REFRESH < 2 || REFRESH_COUNTER_WIDTH < 1) begin : g_bad_refresh
        $error("dram_ctrl: refresh period must be at least 2 cycles");
    end

    typedef struct packed {
        logic cs_n;
        logic ras_n;
        logic cas_n;
        logic we_n;
    } dram_cmd_t;

    // Field order matches {u_cmd, u_addr, u_data_i}, so the request latches as one vector.
    typedef struct packed {
        logic                     wr;
        logic [BANK_ID_WIDTH-1:0] bank;
        logic [ROW_WIDTH-1:0]     row;
        logic [COLUMN_WIDTH-1:0]  col;
        logic [U_DATA_WIDTH-1:0]  dat;
    } req_t;

    localparam dram_cmd_t CMD_NOP    = 4'b0111;
    localparam dram_cmd_t CMD_ACT    = 4'b0011;
    localparam dram_cmd_t CMD_RD     = 4'b0101;
    localparam dram_cmd_t CMD_WR     = 4'b0100;
    localparam dram_cmd_t CMD_PRE    = 4'b0010;
    localparam dram_cmd_t CMD_AREF   = 4'b0001;
    localparam dram_cmd_t CMD_DESEL  = 4'b1111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACTIVATE,
        S_READ,
        S_READ_WAIT,
        S_WRITE,
        S_PRECHARGE,
        S_REFRESH,
        S_REFRESH_WAIT
    } state_t;

    state_t                     state_q, state_d;
    req_t                       req_q, req_in;
    dram_cmd_t                  cmd_q, cmd_d;
    logic [DRAM_ADDR_WIDTH-1:0] addr_d;
    logic [BANK_ID_WIDTH-1:0]   bank_d;
    logic [DRAM_DATA_WIDTH-1:0] wdat_d;
    logic                       ack_d;
    logic                       latch;
    logic                       capture;
    logic                       refresh_due;

    assign req_in = {u_cmd, u_addr, u_data_i};
    assign {dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n} = cmd_q;

`ifdef DRAM_CTRL_REFRESH_EN
    logic [REFRESH_COUNTER_WIDTH-1:0] rf_cnt_q;
    logic                             rf_pend_q;
    logic                             rf_wrap;
    logic                             refresh_clr;

    assign rf_wrap     = (rf_cnt_q == REFRESH_COUNTER_WIDTH'(CYCLES_BETWEEN_REFRESH - 1));
    assign refresh_clr = (state_q == S_REFRESH);
    // The wrap cycle itself counts as due, so a request arriving on that edge loses to refresh.
    assign refresh_due = rf_pend_q | rf_wrap;

    always_ff @(posedge u_clk or negedge u_rst_n) begin
        if (!u_rst_n) begin
            rf_cnt_q  <= '0;
            rf_pend_q <= 1'b0;
        end else begin
            rf_cnt_q <= rf_wrap ? '0 : rf_cnt_q + REFRESH_COUNTER_WIDTH'(1);
            if (rf_wrap) begin
                rf_pend_q <= 1'b1;
            end else if (refresh_clr) begin
                rf_pend_q <= 1'b0;
            end
        end
    end
`else
    // Without refresh the REFRESH states are unreachable and dram_refresh_done has no effect.
    assign refresh_due = 1'b0;
`endif

    // Outputs are registered, so each branch computes the pins for the state being entered.
    always_comb begin
        state_d = state_q;
        cmd_d   = CMD_NOP;
        addr_d  = dram_addr;
        bank_d  = dram_bank_id;
        wdat_d  = dram_wr_data;
        ack_d   = 1'b0;
        latch   = 1'b0;
        capture = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (refresh_due) begin
                    state_d = S_REFRESH;
                    cmd_d   = CMD_AREF;
                end else if (u_en) begin
                    state_d = S_ACTIVATE;
                    cmd_d   = CMD_ACT;
                    addr_d  = DRAM_ADDR_WIDTH'(req_in.row);
                    bank_d  = req_in.bank;
                    ack_d   = 1'b1;
                    latch   = 1'b1;
                end
            end
            S_ACTIVATE: begin
                addr_d = DRAM_ADDR_WIDTH'(req_q.col);
                if (req_q.wr) begin
                    state_d = S_WRITE;
                    cmd_d   = CMD_WR;
                    wdat_d  = req_q.dat;
                end else begin
                    state_d = S_READ;
                    cmd_d   = CMD_RD;
                end
            end
            S_WRITE: begin
                state_d = S_PRECHARGE;
                cmd_d   = CMD_PRE;
                bank_d  = req_q.bank;
            end
            S_READ: begin
                state_d = S_READ_WAIT;
            end
            S_READ_WAIT: begin
                state_d = S_PRECHARGE;
                cmd_d   = CMD_PRE;
                bank_d  = req_q.bank;
                capture = 1'b1;
            end
            S_PRECHARGE: begin
                state_d = S_IDLE;
            end
            S_REFRESH: begin
                state_d = S_REFRESH_WAIT;
            end
            S_REFRESH_WAIT: begin
                if (dram_refresh_done) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge u_clk or negedge u_rst_n) begin
        if (!u_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge u_clk or negedge u_rst_n) begin
        if (!u_rst_n) begin
            req_q        <= '0;
            cmd_q        <= CMD_DESEL;
            dram_addr    <= '0;
            dram_bank_id <= '0;
            dram_wr_data <= '0;
            u_cmd_ack    <= 1'b0;
            u_busy       <= 1'b0;
            u_data_o     <= '0;
            u_data_valid <= 1'b0;
            dram_clk_en  <= 1'b0;
        end else begin
            if (latch) begin
                req_q <= req_in;
            end
            cmd_q        <= cmd_d;
            dram_addr    <= addr_d;
            dram_bank_id <= bank_d;
            dram_wr_data <= wdat_d;
            u_cmd_ack    <= ack_d;
            u_busy       <= (state_d != S_IDLE);
            dram_clk_en  <= 1'b1;
            if (capture) begin
                u_data_o     <= dram_rd_data;
                u_data_valid <= 1'b1;
            end else if (ack_d) begin
                u_data_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dram_ctrl.sv
// Testbench for dram_ctrl: a small DRAM device model answers the command pins, and
// a shadow memory plus address arithmetic predicts every user-visible result.
module tb_dram_ctrl;

    localparam logic [3:0] C_NOP  = 4'b0111;
    localparam logic [3:0] C_ACT  = 4'b0011;
    localparam logic [3:0] C_RD   = 4'b0101;
    localparam logic [3:0] C_WR   = 4'b0100;
    localparam logic [3:0] C_PRE  = 4'b0010;
    localparam logic [3:0] C_AREF = 4'b0001;

    logic        u_clk = 1'b0;
    logic        u_rst_n = 1'b0;
    logic        u_en = 1'b0;
    logic [11:0] u_addr = '0;
    logic [1:0]  u_data_i = '0;
    logic        u_cmd = 1'b0;
    logic [1:0]  u_data_o;
    logic        u_data_valid, u_cmd_ack, u_busy;
    logic [1:0]  dram_rd_data = '0;
    logic        dram_refresh_done = 1'b0;
    logic [1:0]  dram_wr_data;
    logic [6:0]  dram_addr;
    logic [2:0]  dram_bank_id;
    logic        dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n, dram_clk_en;

    wire [3:0] pins = {dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n};

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int rel_cyc = 0;
    int rf_delay = 0;
    int rf_done_cnt = 0;
    logic [1:0] dmem [0:4095];
    logic [1:0] smem [0:4095];

    dram_ctrl dut (
        .u_clk(u_clk), .u_rst_n(u_rst_n), .u_en(u_en), .u_addr(u_addr),
        .u_data_i(u_data_i), .u_cmd(u_cmd), .u_data_o(u_data_o),
        .u_data_valid(u_data_valid), .u_cmd_ack(u_cmd_ack), .u_busy(u_busy),
        .dram_rd_data(dram_rd_data), .dram_refresh_done(dram_refresh_done),
        .dram_wr_data(dram_wr_data), .dram_addr(dram_addr), .dram_bank_id(dram_bank_id),
        .dram_cs_n(dram_cs_n), .dram_ras_n(dram_ras_n), .dram_cas_n(dram_cas_n),
        .dram_we_n(dram_we_n), .dram_clk_en(dram_clk_en)
    );

    initial forever #5 u_clk = ~u_clk;
    initial forever begin
        @(posedge u_clk);
        cyc++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // DRAM device: read data appears one cycle after READ (garbage during the READ cycle),
    // refresh completes after a random 1..6 cycle delay.
    initial begin
        logic [2:0]  lb;
        logic [6:0]  lr;
        logic [11:0] ridx;
        bit          rp;
        int          rc;
        lb = '0; lr = '0; ridx = '0; rp = 0; rc = 0;
        for (int i = 0; i < 4096; i++) dmem[i] = 2'b00;
        forever begin
            @(negedge u_clk);
            dram_refresh_done = 1'b0;
            if (rp) begin
                dram_rd_data = dmem[ridx];
                rp = 0;
            end
            if (rc > 0) begin
                rc--;
                if (rc == 0) begin
                    dram_refresh_done = 1'b1;
                    rf_done_cnt++;
                end
            end
            case (pins)
                C_ACT: begin lb = dram_bank_id; lr = dram_addr; end
                C_WR:  dmem[{lb, lr, dram_addr[1:0]}] = dram_wr_data;
                C_RD: begin
                    ridx = {lb, lr, dram_addr[1:0]};
                    dram_rd_data = ~dmem[ridx];
                    rp = 1;
                end
                C_AREF: begin
                    rf_delay = $urandom_range(1, 6);
                    rc = rf_delay;
                end
                default: ;
            endcase
        end
    end

    task automatic apply_reset();
        @(negedge u_clk);
        u_rst_n = 1'b0;
        u_en = 1'b0;
        repeat (3) @(negedge u_clk);
        u_rst_n = 1'b1;
        rel_cyc = cyc;
    endtask

    // Drives one request and records what the controller did; callers do the checking.
    task automatic issue(input logic cmd, input logic [11:0] addr, input logic [1:0] wdat,
                         output bit tmo, output int acks, output int busy_n,
                         output logic [6:0] arow, output logic [2:0] abank, output logic [23:0] seq,
                         output logic [1:0] wseen, output logic [6:0] cseen,
                         output logic [1:0] rdat, output logic rval, output logic vack);
        tmo = 1; acks = 0; busy_n = 0; arow = '0; abank = '0; seq = '0;
        wseen = '0; cseen = '0; rdat = '0; rval = 1'b0; vack = 1'b0;
        @(negedge u_clk);
        u_en = 1'b1; u_cmd = cmd; u_addr = addr; u_data_i = wdat;
        for (int i = 0; i < 400; i++) begin
            @(negedge u_clk);
            if (u_cmd_ack === 1'b1) begin tmo = 0; break; end
        end
        u_en = 1'b0;
        if (tmo) return;
        acks = 1; arow = dram_addr; abank = dram_bank_id; vack = u_data_valid;
        seq = 24'(pins);
        busy_n = (u_busy === 1'b1) ? 1 : 0;
        tmo = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge u_clk);
            seq = {seq[19:0], pins};
            if (u_cmd_ack === 1'b1) acks++;
            if (pins == C_WR) begin wseen = dram_wr_data; cseen = dram_addr; end
            if (pins == C_RD) cseen = dram_addr;
            if (u_busy !== 1'b1) begin tmo = 0; break; end
            busy_n++;
        end
        rdat = u_data_o;
        rval = u_data_valid;
    endtask

    task automatic test_reset();
        @(negedge u_clk);
        u_rst_n = 1'b0;
        #1;
        n_tests++;
        if (pins !== 4'b1111) begin n_fail++; $display("FAIL reset_pins: got %b want 1111", pins); end
        n_tests++;
        if ({u_busy, u_cmd_ack, u_data_valid, dram_clk_en} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags: got %b want 0000", {u_busy, u_cmd_ack, u_data_valid, dram_clk_en});
        end
        n_tests++;
        if ({u_data_o, dram_addr, dram_bank_id, dram_wr_data} !== 14'd0) begin
            n_fail++; $display("FAIL reset_data: got %h want 0", {u_data_o, dram_addr, dram_bank_id, dram_wr_data});
        end
        repeat (2) @(negedge u_clk);
        u_rst_n = 1'b1;
        rel_cyc = cyc;
        @(negedge u_clk);
        n_tests++;
        if ({dram_clk_en, u_busy, pins} !== {1'b1, 1'b0, C_NOP}) begin
            n_fail++; $display("FAIL post_reset: got clk_en=%b busy=%b pins=%b want 1 0 0111", dram_clk_en, u_busy, pins);
        end
    endtask

    task automatic test_write_read(input logic [11:0] addr, input logic [1:0] d, input string tag);
        bit tmo; int acks, busy_n; logic [6:0] arow, cseen; logic [2:0] abank;
        logic [23:0] seq; logic [1:0] wseen, rdat; logic rval, vack;
        int a = int'(addr);
        issue(1'b1, addr, d, tmo, acks, busy_n, arow, abank, seq, wseen, cseen, rdat, rval, vack);
        smem[addr] = d;
        n_tests++;
        if ({tmo, acks[3:0], busy_n[3:0]} !== {1'b0, 4'd1, 4'd3}) begin
            n_fail++; $display("FAIL %s_wr_ctl: got tmo=%0d acks=%0d busy=%0d want 0 1 3", tag, tmo, acks, busy_n);
        end
        n_tests++;
        if (seq !== 24'h003427) begin n_fail++; $display("FAIL %s_wr_seq: got %h want 003427", tag, seq); end
        n_tests++;
        if ({abank, arow, cseen, wseen} !== {3'(a / 512), 7'((a / 4) % 128), 7'(a % 4), d}) begin
            n_fail++; $display("FAIL %s_wr_fields: got bank=%0d row=%0d col=%0d dat=%b want %0d %0d %0d %b",
                               tag, abank, arow, cseen, wseen, a / 512, (a / 4) % 128, a % 4, d);
        end
        issue(1'b0, addr, 2'b00, tmo, acks, busy_n, arow, abank, seq, wseen, cseen, rdat, rval, vack);
        n_tests++;
        if ({tmo, acks[3:0], busy_n[3:0]} !== {1'b0, 4'd1, 4'd4}) begin
            n_fail++; $display("FAIL %s_rd_ctl: got tmo=%0d acks=%0d busy=%0d want 0 1 4", tag, tmo, acks, busy_n);
        end
        n_tests++;
        if (seq !== 24'h035727) begin n_fail++; $display("FAIL %s_rd_seq: got %h want 035727", tag, seq); end
        n_tests++;
        if ({abank, arow} !== {3'(a / 512), 7'((a / 4) % 128)}) begin
            n_fail++; $display("FAIL %s_rd_act: got bank=%0d row=%0d want %0d %0d", tag, abank, arow, a / 512, (a / 4) % 128);
        end
        n_tests++;
        if ({vack, rval, rdat} !== {1'b0, 1'b1, smem[addr]}) begin
            n_fail++; $display("FAIL %s_rd_data: got vack=%b valid=%b data=%b want 0 1 %b", tag, vack, rval, rdat, smem[addr]);
        end
    endtask

    task automatic test_idle_refresh();
        int ar_n = 0, first = -1, second = -1, run = 0, acks = 0, busy_cycles = 0;
        apply_reset();
        for (int k = 1; k <= 250; k++) begin
            @(negedge u_clk);
            if (pins == C_AREF) begin
                ar_n++;
                if (first < 0) first = k;
                else if (second < 0) second = k;
            end
            if (u_cmd_ack === 1'b1) acks++;
            if (u_busy === 1'b1) begin
                run++;
                busy_cycles++;
            end else if (run > 0) begin
                n_tests++;
                if (run != rf_delay + 1) begin
                    n_fail++; $display("FAIL refresh_busy: got %0d busy cycles want %0d", run, rf_delay + 1);
                end
                run = 0;
            end
        end
        n_tests++;
        if (acks != 0) begin n_fail++; $display("FAIL idle_ack: got %0d acks want 0", acks); end
`ifdef DRAM_CTRL_REFRESH_EN
        n_tests++;
        if (ar_n != 2) begin n_fail++; $display("FAIL refresh_count: got %0d want 2", ar_n); end
        n_tests++;
        if (second - first != 100 || first < 100 || first > 101) begin
            n_fail++; $display("FAIL refresh_period: got first=%0d second=%0d want period 100", first, second);
        end
`else
        n_tests++;
        if (ar_n != 0 || busy_cycles != 0 || rf_done_cnt != 0) begin
            n_fail++; $display("FAIL no_refresh: got refreshes=%0d busy=%0d done=%0d want 0 0 0", ar_n, busy_cycles, rf_done_cnt);
        end
`endif
    endtask

`ifdef DRAM_CTRL_REFRESH_EN
    task automatic test_refresh_priority();
        bit tmo = 1, saw_ar = 0;
        int done0;
        logic [11:0] addr = 12'($urandom_range(0, 4095));
        logic [1:0] d = 2'($urandom_range(0, 3));
        bit t2; int acks, busy_n; logic [6:0] arow, cseen; logic [2:0] abank;
        logic [23:0] seq; logic [1:0] wseen, rdat; logic rval, vack;
        for (int i = 0; i < 400; i++) begin
            @(negedge u_clk);
            if (((cyc - rel_cyc) % 100) == 99 && u_busy === 1'b0) begin tmo = 0; break; end
        end
        n_tests++;
        if (tmo) begin n_fail++; $display("FAIL prio_align: got timeout want counter phase 99"); end
        done0 = rf_done_cnt;
        u_en = 1'b1; u_cmd = 1'b1; u_addr = addr; u_data_i = d;
        tmo = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge u_clk);
            if (pins == C_AREF) saw_ar = 1;
            if (u_cmd_ack === 1'b1) begin tmo = 0; break; end
        end
        u_en = 1'b0;
        n_tests++;
        if ({tmo, saw_ar} !== 2'b01 || rf_done_cnt - done0 != 1) begin
            n_fail++; $display("FAIL prio_order: got tmo=%0d refresh_first=%0d done=%0d want 0 1 1",
                               tmo, saw_ar, rf_done_cnt - done0);
        end
        for (int i = 0; i < 20 && u_busy === 1'b1; i++) @(negedge u_clk);
        smem[addr] = d;
        issue(1'b0, addr, 2'b00, t2, acks, busy_n, arow, abank, seq, wseen, cseen, rdat, rval, vack);
        n_tests++;
        if ({t2, rval, rdat} !== {1'b0, 1'b1, d}) begin
            n_fail++; $display("FAIL prio_readback: got tmo=%0d valid=%b data=%b want 0 1 %b", t2, rval, rdat, d);
        end
    endtask
`endif

    task automatic test_reset_mid_read();
        bit tmo = 1;
        logic [11:0] addr = 12'($urandom_range(0, 4095));
        @(negedge u_clk);
        u_en = 1'b1; u_cmd = 1'b0; u_addr = addr;
        for (int i = 0; i < 400; i++) begin
            @(negedge u_clk);
            if (u_cmd_ack === 1'b1) begin tmo = 0; break; end
        end
        u_en = 1'b0;
        @(negedge u_clk);
        n_tests++;
        if ({tmo, pins} !== {1'b0, C_RD}) begin n_fail++; $display("FAIL rst_rd_cmd: got tmo=%0d pins=%b want 0 0101", tmo, pins); end
        @(negedge u_clk);
        n_tests++;
        if ({u_busy, pins} !== {1'b1, C_NOP}) begin n_fail++; $display("FAIL rst_rd_wait: got busy=%b pins=%b want 1 0111", u_busy, pins); end
        u_rst_n = 1'b0;
        #1;
        n_tests++;
        if ({pins, u_busy, u_cmd_ack, u_data_valid, dram_clk_en} !== 8'b1111_0000) begin
            n_fail++; $display("FAIL rst_async_ctl: got %b want 11110000", {pins, u_busy, u_cmd_ack, u_data_valid, dram_clk_en});
        end
        n_tests++;
        if ({u_data_o, dram_addr, dram_bank_id, dram_wr_data} !== 14'd0) begin
            n_fail++; $display("FAIL rst_async_data: got %h want 0", {u_data_o, dram_addr, dram_bank_id, dram_wr_data});
        end
        repeat (2) @(negedge u_clk);
        u_rst_n = 1'b1;
        rel_cyc = cyc;
        test_write_read(addr, 2'($urandom_range(1, 3)), "after_rst");
    endtask

    task automatic test_random();
        logic [11:0] pool [0:7];
        bit tmo; int acks, busy_n; logic [6:0] arow, cseen; logic [2:0] abank;
        logic [23:0] seq; logic [1:0] wseen, rdat, d; logic rval, vack, cmd; logic [11:0] addr;
        int a;
        for (int i = 0; i < 8; i++) pool[i] = 12'($urandom_range(0, 4095));
        for (int n = 0; n < 100; n++) begin
            cmd = 1'($urandom_range(0, 1));
            addr = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(0, 4095)) : pool[$urandom_range(0, 7)];
            d = 2'($urandom_range(0, 3));
            a = int'(addr);
            issue(cmd, addr, d, tmo, acks, busy_n, arow, abank, seq, wseen, cseen, rdat, rval, vack);
            n_tests++;
            if ({tmo, acks[3:0], busy_n[3:0]} !== {1'b0, 4'd1, (cmd ? 4'd3 : 4'd4)}) begin
                n_fail++; $display("FAIL rnd_ctl[%0d]: got tmo=%0d acks=%0d busy=%0d want 0 1 %0d", n, tmo, acks, busy_n, cmd ? 3 : 4);
            end
            n_tests++;
            if ({abank, arow, cseen} !== {3'(a / 512), 7'((a / 4) % 128), 7'(a % 4)}) begin
                n_fail++; $display("FAIL rnd_addr[%0d]: got bank=%0d row=%0d col=%0d want %0d %0d %0d",
                                   n, abank, arow, cseen, a / 512, (a / 4) % 128, a % 4);
            end
            if (cmd) begin
                smem[addr] = d;
                n_tests++;
                if (wseen !== d) begin n_fail++; $display("FAIL rnd_wdata[%0d]: got %b want %b", n, wseen, d); end
            end else begin
                n_tests++;
                if ({vack, rval, rdat} !== {1'b0, 1'b1, smem[addr]}) begin
                    n_fail++; $display("FAIL rnd_rdata[%0d] addr=%h: got vack=%b valid=%b data=%b want 0 1 %b",
                                       n, addr, vack, rval, rdat, smem[addr]);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) smem[i] = 2'b00;
        test_reset();
        test_write_read(12'h5A3, 2'b10, "basic");
        test_write_read(12'hFFF, 2'b01, "corner");
        test_idle_refresh();
`ifdef DRAM_CTRL_REFRESH_EN
        test_refresh_priority();
`endif
        test_reset_mid_read();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
